jtsdram_ro_seq: RTL and testbench

//  Test sequencer upstream of the read-only bank checkers. Issues the start

---
 rtl/jtsdram_ro_seq.sv | 137 +++++++++++++
 tb/tb_jtsdram_ro_seq.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtsdram_ro_seq.sv
// jtsdram_ro_seq
// Test sequencer that drives a group of read-only bank checkers in parallel.
// It waits for vertical blanking and then fires a common start pulse. It waits
// until every checker reports done, then folds the per-bank bad flags into a
// sticky mask and counts the completed passes. Passes alternate between fast
// and slow mode. A pass that never completes is caught by a timeout.
//
// Ports:
//   clk       system clock
//   rst_n     asynchronous reset, active low
//   enable    run passes back to back while high
//   halt_bad  stop after the first pass that reports any bad bank
//   LVBL      vertical blank, active low
//   ck_done   per-checker done flags
//   ck_bad    per-checker bad flags
//   start     one-clock start pulse common to all checkers
//   slow      slow-mode select, constant during a pass
//   busy      high from the start pulse until the pass is evaluated
//   pass_cnt  completed passes, saturating
//   bad_mask  sticky OR of ck_bad captured at the end of each pass
//   timeout   sticky hang indicator
//   fail      registered |bad_mask | timeout

module jtsdram_ro_seq #(
    parameter int BANKS  = 4,
    parameter int TOUT_W = 24,
    parameter int PASS_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              halt_bad,
    input  logic              LVBL,
    input  logic [BANKS-1:0]  ck_done,
    input  logic [BANKS-1:0]  ck_bad,
    output logic              start,
    output logic              slow,
    output logic              busy,
    output logic [PASS_W-1:0] pass_cnt,
    output logic [BANKS-1:0]  bad_mask,
    output logic              timeout,
    output logic              fail
);

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        START,
        GUARD,
        WAIT,
        EVAL,
        HALT
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [TOUT_W-1:0] tout_cnt;
    logic              all_done;
    logic              tout_max;
    logic [BANKS-1:0]  new_mask;

    assign all_done = &ck_done;
    assign tout_max = &tout_cnt;
    assign new_mask = bad_mask | ck_bad;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The guard period reuses the timeout counter. It is cleared in START,
    // so it reads 0 and then 1 during the two GUARD cycles. A checker can
    // only take one clock to clear done, so this covers that latency.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (enable) state_nxt = ARM;
            ARM: begin
                if (!enable)    state_nxt = IDLE;
                else if (!LVBL) state_nxt = START;
            end
            START: state_nxt = GUARD;
            GUARD: if (tout_cnt == TOUT_W'(1)) state_nxt = WAIT;
            WAIT: begin
                if (all_done)      state_nxt = EVAL;
                else if (tout_max) state_nxt = HALT;
            end
            EVAL: begin
                if (halt_bad && (new_mask != '0)) state_nxt = HALT;
                else if (enable)                  state_nxt = ARM;
                else                              state_nxt = IDLE;
            end
            HALT:  if (!enable) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        start = (state == START);
        busy  = (state == START) || (state == GUARD) ||
                (state == WAIT)  || (state == EVAL);
    end

    // Pass results are written only in EVAL and the timeout flag only in
    // WAIT, so the outputs stay frozen in HALT. The counter stops at its
    // maximum so a hung pass cannot wrap it back to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tout_cnt <= '0;
            timeout  <= 1'b0;
            bad_mask <= '0;
            pass_cnt <= '0;
            slow     <= 1'b0;
            fail     <= 1'b0;
        end else begin
            fail <= (|bad_mask) | timeout;
            case (state)
                START: tout_cnt <= '0;
                GUARD: tout_cnt <= tout_cnt + 1'b1;
                WAIT: begin
                    if (!tout_max) tout_cnt <= tout_cnt + 1'b1;
                    if (!all_done && tout_max) timeout <= 1'b1;
                end
                EVAL: begin
                    bad_mask <= new_mask;
                    if (!(&pass_cnt)) pass_cnt <= pass_cnt + 1'b1;
                    slow <= ~slow;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_jtsdram_ro_seq.sv
// tb_jtsdram_ro_seq
// Self-checking bench for jtsdram_ro_seq. A behavioural checker model drives
// ck_done and ck_bad. After each start pulse, every bank lowers done and
// raises it again after a random delay, unless that bank is set to hang. The
// expected counters and flags come from simple pass-level bookkeeping.

module tb_jtsdram_ro_seq;

    localparam int BANKS  = 4;
    localparam int TOUT_W = 8;
    localparam int PASS_W = 3;
    localparam int PASS_MAX = (1 << PASS_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              enable;
    logic              halt_bad;
    logic              LVBL;
    logic [BANKS-1:0]  ck_done = '1;
    logic [BANKS-1:0]  ck_bad = '0;
    logic              start;
    logic              slow;
    logic              busy;
    logic [PASS_W-1:0] pass_cnt;
    logic [BANKS-1:0]  bad_mask;
    logic              timeout;
    logic              fail;

    int total = 0;
    int bad = 0;

    int               dly[BANKS];
    int               cnt[BANKS];
    logic [BANKS-1:0] hang;
    logic [BANKS-1:0] bad_plan;

    int               exp_cnt;
    logic             exp_slow;
    logic [BANKS-1:0] exp_mask;

    jtsdram_ro_seq #(.BANKS(BANKS), .TOUT_W(TOUT_W), .PASS_W(PASS_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .halt_bad (halt_bad),
        .LVBL     (LVBL),
        .ck_done  (ck_done),
        .ck_bad   (ck_bad),
        .start    (start),
        .slow     (slow),
        .busy     (busy),
        .pass_cnt (pass_cnt),
        .bad_mask (bad_mask),
        .timeout  (timeout),
        .fail     (fail)
    );

    always #5 clk = ~clk;

    // Checker model: a start pulse reloads each bank's delay and applies the
    // planned bad flags for the pass.
    always @(negedge clk) begin
        if (start === 1'b1) begin
            for (int b = 0; b < BANKS; b++) begin
                cnt[b] = dly[b];
                ck_done[b] = 1'b0;
            end
            ck_bad = bad_plan;
        end else begin
            for (int b = 0; b < BANKS; b++) begin
                if (cnt[b] > 0) cnt[b] = cnt[b] - 1;
                ck_done[b] = (cnt[b] == 0) && !hang[b];
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        enable = 1'b0;
        halt_bad = 1'b0;
        LVBL = 1'b0;
        hang = '0;
        bad_plan = '0;
        for (int b = 0; b < BANKS; b++) begin
            dly[b] = 50;
            cnt[b] = 0;
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        exp_cnt = 0;
        exp_slow = 1'b0;
        exp_mask = '0;
    endtask

    task automatic wait_start(input int maxc, input string name);
        int n = 0;
        while (start !== 1'b1 && n < maxc) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (start !== 1'b1) begin
            bad++;
            $display("[TB] FAIL %s start: got %b after %0d clks, expected 1", name, start, maxc);
        end
    endtask

    task automatic wait_idle(input int maxc, input string name);
        int n = 0;
        while (busy !== 1'b0 && n < maxc) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL %s busy_end: got %b after %0d clks, expected 0", name, busy, maxc);
        end
    endtask

    task automatic count_starts(input int cycles, output int starts);
        starts = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (start === 1'b1) starts++;
        end
    endtask

    // Runs one complete pass, then checks the pass-level results.
    task automatic run_pass(input logic [BANKS-1:0] badp, input string name);
        bad_plan = badp;
        for (int b = 0; b < BANKS; b++) dly[b] = $urandom_range(20, 150);
        wait_start(400, name);
        total++;
        if (busy !== 1'b1 || slow !== exp_slow) begin
            bad++;
            $display("[TB] FAIL %s at_start: busy=%b slow=%b, expected busy=1 slow=%b", name, busy, slow, exp_slow);
        end
        @(negedge clk);
        total++;
        if (start !== 1'b0) begin
            bad++;
            $display("[TB] FAIL %s pulse_width: start=%b one clk later, expected 0", name, start);
        end
        wait_idle(400, name);
        exp_cnt = (exp_cnt < PASS_MAX) ? exp_cnt + 1 : PASS_MAX;
        exp_slow = ~exp_slow;
        exp_mask = exp_mask | badp;
        total++;
        if (pass_cnt !== PASS_W'(exp_cnt) || slow !== exp_slow || bad_mask !== exp_mask) begin
            bad++;
            $display("[TB] FAIL %s result: pass_cnt=%0d slow=%b bad_mask=%b, expected %0d %b %b", name, pass_cnt, slow, bad_mask, exp_cnt, exp_slow, exp_mask);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        enable = 1'b0;
        @(negedge clk);
        total++;
        if ({start, slow, busy, timeout, fail} !== 5'b0 || pass_cnt !== '0 || bad_mask !== '0) begin
            bad++;
            $display("[TB] FAIL reset_state: start=%b slow=%b busy=%b cnt=%0d mask=%b tout=%b fail=%b, expected all 0", start, slow, busy, pass_cnt, bad_mask, timeout, fail);
        end
        do_reset();
    endtask

    task automatic test_clean();
        do_reset();
        enable = 1'b1;
        for (int p = 0; p < 4; p++) run_pass('0, "clean");
        @(negedge clk);
        total++;
        if (fail !== 1'b0) begin
            bad++;
            $display("[TB] FAIL clean_fail: got %b, expected 0", fail);
        end
        enable = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_lvbl();
        int starts;
        do_reset();
        LVBL = 1'b1;
        enable = 1'b1;
        count_starts(60, starts);
        total++;
        if (starts != 0) begin
            bad++;
            $display("[TB] FAIL lvbl_block: got %0d starts, expected 0", starts);
        end
        LVBL = 1'b0;
        wait_start(2, "lvbl_release");
        wait_idle(400, "lvbl_release");
        enable = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_halt_bad();
        int starts;
        int b;
        do_reset();
        b = $urandom_range(0, BANKS - 1);
        halt_bad = 1'b1;
        enable = 1'b1;
        run_pass('0, "halt_p1");
        run_pass('0, "halt_p2");
        run_pass(BANKS'(1) << b, "halt_p3");
        total++;
        if (fail !== 1'b0) begin
            bad++;
            $display("[TB] FAIL halt_fail_lag: got %b on the first idle clk, expected 0", fail);
        end
        @(negedge clk);
        total++;
        if (fail !== 1'b1) begin
            bad++;
            $display("[TB] FAIL halt_fail: got %b, expected 1", fail);
        end
        count_starts(300, starts);
        total++;
        if (starts != 0 || busy !== 1'b0 || pass_cnt !== PASS_W'(3) || slow !== exp_slow) begin
            bad++;
            $display("[TB] FAIL halt_frozen: starts=%0d busy=%b cnt=%0d slow=%b, expected 0 0 3 %b", starts, busy, pass_cnt, slow, exp_slow);
        end
        enable = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_timeout();
        int n;
        int starts;
        do_reset();
        hang[$urandom_range(0, BANKS - 1)] = 1'b1;
        for (int b = 0; b < BANKS; b++) dly[b] = 40;
        enable = 1'b1;
        wait_start(10, "tout");
        n = 0;
        while (timeout !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (timeout !== 1'b1 || n < 250 || n > 262) begin
            bad++;
            $display("[TB] FAIL tout_time: timeout=%b after %0d clks, expected 1 after about 255", timeout, n);
        end
        total++;
        if (busy !== 1'b0 || pass_cnt !== '0 || bad_mask !== '0) begin
            bad++;
            $display("[TB] FAIL tout_state: busy=%b cnt=%0d mask=%b, expected 0 0 0", busy, pass_cnt, bad_mask);
        end
        @(negedge clk);
        total++;
        if (fail !== 1'b1) begin
            bad++;
            $display("[TB] FAIL tout_fail: got %b, expected 1", fail);
        end
        count_starts(100, starts);
        total++;
        if (starts != 0) begin
            bad++;
            $display("[TB] FAIL tout_hold: got %0d starts, expected 0", starts);
        end
        hang = '0;
        enable = 1'b0;
        repeat (3) @(negedge clk);
        enable = 1'b1;
        run_pass('0, "tout_restart");
        total++;
        if (timeout !== 1'b1) begin
            bad++;
            $display("[TB] FAIL tout_sticky: got %b, expected 1", timeout);
        end
        enable = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_enable_drop();
        int starts;
        do_reset();
        for (int b = 0; b < BANKS; b++) dly[b] = 100;
        enable = 1'b1;
        wait_start(10, "drop");
        repeat (30) @(negedge clk);
        enable = 1'b0;
        wait_idle(200, "drop");
        total++;
        if (pass_cnt !== PASS_W'(1) || slow !== 1'b1) begin
            bad++;
            $display("[TB] FAIL drop_result: cnt=%0d slow=%b, expected 1 1", pass_cnt, slow);
        end
        count_starts(200, starts);
        total++;
        if (starts != 0) begin
            bad++;
            $display("[TB] FAIL drop_idle: got %0d starts, expected 0", starts);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        enable = 1'b1;
        for (int p = 0; p < 9; p++) run_pass('0, "sat");
        for (int b = 0; b < BANKS; b++) dly[b] = 100;
        wait_start(10, "midreset");
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({start, slow, busy, timeout, fail} !== 5'b0 || pass_cnt !== '0 || bad_mask !== '0) begin
            bad++;
            $display("[TB] FAIL midreset: start=%b slow=%b busy=%b cnt=%0d mask=%b tout=%b fail=%b, expected all 0", start, slow, busy, pass_cnt, bad_mask, timeout, fail);
        end
        do_reset();
    endtask

    initial begin
        rst_n = 1'b0;
        enable = 1'b0;
        halt_bad = 1'b0;
        LVBL = 1'b0;
        hang = '0;
        bad_plan = '0;
        for (int b = 0; b < BANKS; b++) begin
            dly[b] = 50;
            cnt[b] = 0;
        end
        test_reset();
        test_clean();
        test_lvbl();
        test_halt_bad();
        test_timeout();
        test_enable_drop();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
